// File: rtl/spi_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : spi_frame_rx
//  Description : SPI mode-0 frame receiver. Synchronises SCLK/COPI/nCS into
//                the clk domain, shifts in 16-bit MSB-first frames
//                {R/W, addr[6:0], data[7:0]} and, when nCS rises, emits a
//                single-cycle write strobe for each good write frame.
//                Frames with a bit count other than 16 pulse frame_err and
//                bump the saturating drop counter.
//                Optional macro SPI_RX_ADDR_FILTER_EN: only addresses
//                0x00-0x04 commit; other write addresses are dropped
//                (drop_cnt +1, no strobe, no error).
//                SYNC_STAGES legal range is 2..3.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err,
    output logic [7:0] drop_cnt
);

    localparam logic [4:0] C_FRAME_BITS = 5'd16;
    localparam logic [4:0] C_CNT_SAT    = 5'd17;
    localparam logic [6:0] C_ADDR_MAX   = 7'd4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Synchroniser chains and edge-detect delay flops
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic [SYNC_STAGES-1:0] ncs_sync_q;
    logic                   sclk_dly_q;
    logic                   ncs_dly_q;

    logic sclk_s;
    logic copi_s;
    logic ncs_s;
    logic sclk_rise;
    logic ncs_rise;
    logic ncs_fall;

    // Frame state
    state_t      state_q,     state_d;
    logic [15:0] shift_q,     shift_d;
    logic [4:0]  cnt_q,       cnt_d;
    logic        wr_valid_q,  wr_valid_d;
    logic        frame_err_q, frame_err_d;
    logic [6:0]  addr_q,      addr_d;
    logic [7:0]  data_q,      data_d;
    logic [7:0]  drop_q,      drop_d;
    logic        addr_ok;

    // Bring the asynchronous pins into the clk domain; nCS idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_dly_q  <= 1'b0;
            ncs_dly_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
            ncs_dly_q   <= ncs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign ncs_rise  = ncs_s & ~ncs_dly_q;
    assign ncs_fall  = ~ncs_s & ncs_dly_q;

`ifdef SPI_RX_ADDR_FILTER_EN
    assign addr_ok = (shift_q[14:8] <= C_ADDR_MAX);
`else
    assign addr_ok = 1'b1;
`endif

    // Next-state logic: frame shifting and the commit decision on nCS rise.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        wr_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        drop_d      = drop_q;

        case (state_q)
            ST_IDLE: begin
                if (ncs_fall) begin
                    state_d = ST_SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (ncs_rise) begin
                    state_d = ST_IDLE;
                    if (cnt_q == C_FRAME_BITS) begin
                        if (shift_q[15]) begin
                            if (addr_ok) begin
                                wr_valid_d = 1'b1;
                                addr_d     = shift_q[14:8];
                                data_d     = shift_q[7:0];
                            end else if (drop_q != 8'hFF) begin
                                drop_d = drop_q + 8'd1;
                            end
                        end
                        // Read frames are discarded without any side effect.
                    end else begin
                        frame_err_d = 1'b1;
                        if (drop_q != 8'hFF) begin
                            drop_d = drop_q + 8'd1;
                        end
                    end
                end else if (ncs_fall) begin
                    // A fresh select edge restarts the frame; the partial
                    // frame is thrown away silently.
                    shift_d = '0;
                    cnt_d   = '0;
                end else if (sclk_rise && !ncs_s) begin
                    shift_d = {shift_q[14:0], copi_s};
                    if (cnt_q < C_CNT_SAT) begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register frame state and all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            wr_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            wr_valid_q  <= wr_valid_d;
            frame_err_q <= frame_err_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            drop_q      <= drop_d;
        end
    end

    assign wr_valid  = wr_valid_q;
    assign frame_err = frame_err_q;
    assign wr_addr   = addr_q;
    assign wr_data   = data_q;
    assign drop_cnt  = drop_q;

endmodule
`default_nettype wire
